// File: rtl/y86_regfile.sv
// SEQ Y86-64 register file: 15 x DATA_W program registers, asynchronous reads,
// synchronous writes on two ports (valE/valM) and a committed-write counter.
module y86_regfile #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] STACK_INIT = 64'h0000_0000_0000_0200,
  parameter int                NREGS      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  input  logic [3:0]        dstE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              halt,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [DATA_W-1:0] rsp_out,
  output logic [31:0]       wr_count
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              e_we_s;
  logic              m_we_s;
  logic              e_kept_s;

  assign e_we_s   = (dstE != RNONE);
  assign m_we_s   = (dstM != RNONE);
  // A same-register collision keeps only valM, so the E port does not count.
  assign e_kept_s = e_we_s && !(m_we_s && (dstE == dstM));

  assign valA     = (srcA == RNONE) ? {DATA_W{1'b0}} : regs_q[srcA];
  assign valB     = (srcB == RNONE) ? {DATA_W{1'b0}} : regs_q[srcB];
  assign rsp_out  = regs_q[RRSP];
  assign wr_count = wr_count_q;

  // Next-state: apply E then M so that M overrides E on a collision.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    wr_count_d = wr_count_q;
    if (!halt) begin
      if (e_we_s) begin
        regs_d[dstE] = valE;
      end else begin
        regs_d[RRSP] = regs_q[RRSP];
      end
      if (m_we_s) begin
        regs_d[dstM] = valM;
      end else begin
        regs_d[RRSP] = regs_d[RRSP];
      end
      wr_count_d = wr_count_q + {31'd0, e_kept_s} + {31'd0, m_we_s};
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // State update; reset discards any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == int'(RRSP)) ? STACK_INIT : {DATA_W{1'b0}};
      end
      wr_count_q <= 32'd0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_count_q <= wr_count_d;
    end
  end

endmodule
